// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential multiply/shift unit: op and state encodings,
// plus the ALU control word and its per-state base values.
package alu_seq_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_SHR = 2'b01,
        OP_SAR = 2'b10,
        OP_SHL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DBL  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic ci;
        logic nb;
        logic ic;
        logic zb;
        logic na;
        logic xo;
        logic no;
    } alu_ctrl_t;

    localparam alu_ctrl_t CTRL_IDLE = '0;
    localparam alu_ctrl_t CTRL_DBL  = '0;
    localparam alu_ctrl_t CTRL_ADD  = '0;

    // Only ci (doubling) and zb (adding) vary step to step.
    function automatic alu_ctrl_t ctrl_dbl(input logic ci);
        alu_ctrl_t c;
        c    = CTRL_DBL;
        c.ci = ci;
        return c;
    endfunction

    function automatic alu_ctrl_t ctrl_add(input logic mult_bit);
        alu_ctrl_t c;
        c    = CTRL_ADD;
        c.zb = ~mult_bit;
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: start pulse with operands in, busy/done with result out.
interface alu_seq_if;
    import alu_seq_pkg::*;

    logic        start;
    op_e         op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        flag;

    modport master (output start, op, a, b, input busy, done, result, flag);
    modport slave  (input start, op, a, b, output busy, done, result, flag);
endinterface

// File: rtl/alu_seq_alu.sv
// Combinational 16-bit ALU: optional invert/zero of operands, add or xor, optional invert of output.
// Zero latency; no flow control.
module alu_seq_alu
    import alu_seq_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  alu_ctrl_t   ctrl_i,
    output logic [15:0] out_o,
    output logic        co_o
);
    logic [15:0] ax;
    logic [15:0] bz;
    logic [15:0] bx;
    logic        cin;
    logic [16:0] sum;
    logic [15:0] raw;

    always_comb begin
        ax  = ctrl_i.na ? ~a_i : a_i;
        bz  = ctrl_i.zb ? 16'd0 : b_i;
        bx  = ctrl_i.nb ? ~bz : bz;
        cin = ctrl_i.ci ^ ctrl_i.ic;
        sum = {1'b0, ax} + {1'b0, bx} + {16'd0, cin};
        raw = ctrl_i.xo ? (ax ^ bx) : sum[15:0];
        out_o = ctrl_i.no ? ~raw : raw;
        co_o  = sum[16];
    end
endmodule

// File: rtl/alu_seq.sv
// Sequential MUL/SHR/SAR/SHL built on one shared ALU; 2 to 33 cycles from start to done.
// start is only sampled in IDLE; requests while busy or in DONE are dropped.
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] r_q, r_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ext_q, ext_d;
    logic        flag_q, flag_d;
    logic [15:0] result_q, result_d;

    alu_ctrl_t   alu_ctrl;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic        alu_co;
    logic        shift_op;

    alu_seq_alu u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .ctrl_i (alu_ctrl),
        .out_o  (alu_out),
        .co_o   (alu_co)
    );

    assign shift_op = (op_q == OP_SHR) || (op_q == OP_SAR);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        ext_d    = ext_q;
        flag_d   = flag_q;
        result_d = result_q;
        alu_ctrl = CTRL_IDLE;
        alu_a    = r_q;
        alu_b    = r_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    r_d     = (bus.op == OP_SHL) ? bus.a : 16'd0;
                    flag_d  = 1'b0;
                    cnt_d   = 4'd15;
                    ext_d   = (bus.op == OP_SAR);
                    state_d = S_DBL;
                end
            end
            S_DBL: begin
                // Shifts feed operand bits in MSB-first through the doubling carry-in.
                alu_ctrl = ctrl_dbl(shift_op && (ext_q ? a_q[15] : a_q[cnt_q]));
                r_d      = alu_out;
                unique case (op_q)
                    OP_MUL: begin
                        flag_d  = flag_q | alu_co;
                        state_d = S_ADD;
                    end
                    OP_SHL: begin
                        flag_d  = alu_co;
                        state_d = S_DONE;
                    end
                    default: begin
                        if (ext_q) begin
                            ext_d = 1'b0;
                        end else if (cnt_q == 4'd1) begin
                            flag_d  = a_q[0];
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                endcase
            end
            S_ADD: begin
                alu_ctrl = ctrl_add(b_q[cnt_q]);
                alu_b    = a_q;
                r_d      = alu_out;
                flag_d   = flag_q | alu_co;
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = S_DBL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Capture on entry to DONE so result is already valid while done is high.
        if ((state_q != S_DONE) && (state_d == S_DONE)) begin
            result_d = r_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            ext_q    <= 1'b0;
            flag_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            ext_q    <= ext_d;
            flag_q   <= flag_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == S_DBL) || (state_q == S_ADD);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.flag   = flag_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: latency, busy span, result/flag per op, reset abort, held start.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;
    int   lat;
    int   bcnt;
    int   dones;
    logic [15:0] res;

    alu_seq_if bus();

    alu_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request at the current (non-edge) time; edge n counts the accepting edge as 1.
    task automatic go(input op_e o, input logic [15:0] av, input logic [15:0] bv,
                      output int l, output int bc);
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        l  = -1;
        bc = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                bus.start = 1'b0;
                bus.a     = ~av;
                bus.b     = ~bv;
                bus.op    = op_e'(~o);
            end
            if (bus.busy) bc++;
            if (bus.done) begin
                l = n;
                break;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.a     = 16'd0;
        bus.b     = 16'd0;

        #3;
        check("rst_busy",   {31'd0, bus.busy}, 32'd0);
        check("rst_done",   {31'd0, bus.done}, 32'd0);
        check("rst_result", {16'd0, bus.result}, 32'd0);
        check("rst_flag",   {31'd0, bus.flag}, 32'd0);

        // Start is presented together with reset release.
        @(negedge clk);
        rst_n = 1'b1;
        go(OP_MUL, 16'd7, 16'd9, lat, bcnt);
        check("mul79_lat",    lat, 33);
        check("mul79_busy",   bcnt, 32);
        check("mul79_result", {16'd0, bus.result}, 32'd63);
        check("mul79_flag",   {31'd0, bus.flag}, 32'd0);
        check("mul79_busy_at_done", {31'd0, bus.busy}, 32'd0);

        next_cycle();
        go(OP_MUL, 16'd300, 16'd300, lat, bcnt);
        check("mul300_lat",    lat, 33);
        check("mul300_result", {16'd0, bus.result}, 32'h5F90);
        check("mul300_flag",   {31'd0, bus.flag}, 32'd1);

        next_cycle();
        go(OP_SHR, 16'h8001, 16'h1234, lat, bcnt);
        check("shr_lat",    lat, 16);
        check("shr_result", {16'd0, bus.result}, 32'h4000);
        check("shr_flag",   {31'd0, bus.flag}, 32'd1);

        next_cycle();
        go(OP_SAR, 16'h8004, 16'h0000, lat, bcnt);
        check("sar_lat",    lat, 17);
        check("sar_result", {16'd0, bus.result}, 32'hC002);
        check("sar_flag",   {31'd0, bus.flag}, 32'd0);

        next_cycle();
        go(OP_SHL, 16'h8001, 16'h0000, lat, bcnt);
        check("shl_lat",    lat, 2);
        check("shl_result", {16'd0, bus.result}, 32'h0002);
        check("shl_flag",   {31'd0, bus.flag}, 32'd1);

        // Request in the first IDLE cycle after DONE must be accepted at once.
        next_cycle();
        go(OP_SHL, 16'h4000, 16'h0000, lat, bcnt);
        check("shl2_lat",    lat, 2);
        check("shl2_result", {16'd0, bus.result}, 32'h8000);
        check("shl2_flag",   {31'd0, bus.flag}, 32'd0);

        // Abort a multiply at cycle 10 with an asynchronous reset.
        next_cycle();
        bus.op    = OP_MUL;
        bus.a     = 16'd7;
        bus.b     = 16'd9;
        bus.start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy",   {31'd0, bus.busy}, 32'd0);
        check("abort_done",   {31'd0, bus.done}, 32'd0);
        check("abort_result", {16'd0, bus.result}, 32'd0);
        check("abort_flag",   {31'd0, bus.flag}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);

        go(OP_MUL, 16'd7, 16'd9, lat, bcnt);
        check("mul_after_rst_lat",    lat, 33);
        check("mul_after_rst_result", {16'd0, bus.result}, 32'd63);

        // start held through the whole multiply while operands wander.
        next_cycle();
        bus.op    = OP_MUL;
        bus.a     = 16'd5;
        bus.b     = 16'd11;
        bus.start = 1'b1;
        dones = 0;
        lat   = -1;
        res   = 16'hDEAD;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            bus.a = 16'(k * 3 + 1);
            bus.b = 16'(k + 100);
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = k;
                    res = bus.result;
                end
                bus.start = 1'b0;
            end
        end
        check("held_dones",  dones, 1);
        check("held_lat",    lat, 33);
        check("held_result", {16'd0, res}, 32'd55);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameters: none; datapath fixed at 16 bits to match ALU.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MUL, 01 SHR (logical right 1), 10 SAR (arithmetic right 1), 11 SHL (left 1).
REQ-006 a  input  16  operand A (value to shift for SHR/SAR/SHL; multiplicand for MUL).
REQ-007 b  input  16  operand B (multiplier for MUL; ignored otherwise).
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse; result and flag valid.
REQ-010 result  output  16  registered result, held until next accepted start.
REQ-011 flag  output  1  MUL: unsigned overflow; SHR/SAR: bit shifted out (a[0]); SHL: bit shifted out (a[15]).

Function
REQ-012 States: IDLE, DBL, ADD, DONE; all arithmetic goes through one ALU instance.
REQ-013 IDLE + start: latch a, b, op; clear accumulator r and flag; load 4-bit step counter; go to DBL.
REQ-014 DBL drives ALU a=r, b=r, all controls 0 except ci; r <= out (r+r+ci).
REQ-015 ADD drives ALU a=r, b=latched a, ci=0, zb = NOT current multiplier bit; r <= out.
REQ-016 MUL: counter i 15 down to 0; each i does DBL (ci=0) then ADD using b[i]; 32 ALU cycles; done on the 33rd cycle after start.
REQ-017 MUL flag = OR of ALU co over all 32 steps; result = (a*b) mod 65536.
REQ-018 SHR: DBL steps with ci = a[i] for i 15 down to 1 (15 cycles); result = a >> 1; done on cycle 16.
REQ-019 SAR: first DBL with ci = a[15], then SHR sequence (16 cycles); result = a >>> 1; done on cycle 17.
REQ-020 SHL: single DBL with r = latched a, ci=0; result = a+a; flag = co; done on cycle 2.
REQ-021 DONE: result <= r, done=1, busy=0; next state IDLE unconditionally.
REQ-022 start while busy or in DONE is ignored; no queuing.
REQ-023 start in IDLE on the cycle after DONE is accepted (back-to-back, no dead cycle beyond DONE).
REQ-024 Inputs a, b, op may change after acceptance without affecting the running operation.
REQ-025 ALU controls na, nb, ic, xo, no are held 0 in all states; zb=0 outside ADD.

Reset
REQ-026 rst_n low: state IDLE, busy=0, done=0, result=0, flag=0, r=0, counter=0, immediately and independent of clk.
REQ-027 Reset mid-operation aborts it; no done pulse is produced for the aborted operation.
REQ-028 First start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package alu_seq_pkg holds the op encoding enum, state enum, and per-state ALU control-word constants (ci, nb, ic, zb, na, xo, no bundle).
REQ-030 Single sub-module: existing ALU, instantiated once; no other arithmetic operators on the 16-bit datapath except counter decrement.
REQ-031 Target size 120-250 lines of RTL excluding package.

Verification
REQ-032 MUL a=7, b=9 -> done exactly 33 cycles after start, result=63, flag=0, busy high cycles 1-32.
REQ-033 MUL a=300, b=300 -> result=24464 (0x5F90), flag=1.
REQ-034 SHR a=0x8001 -> result=0x4000, flag=1, done on cycle 16; SAR a=0x8004 -> result=0xC002, flag=0, done on cycle 17.
REQ-035 SHL a=0x8001 -> result=0x0002, flag=1, done on cycle 2; second start on following cycle accepted.
REQ-036 rst_n pulsed low at cycle 10 of a MUL -> outputs 0 asynchronously, no done pulse; a fresh MUL 7*9 afterwards completes with 63.
REQ-037 start held high throughout a MUL with changing a/b -> exactly one done, result from operands latched at acceptance.
